// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus between the execute stage, the load/store unit and memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_misaligned, resp_error,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_misaligned, resp_error,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per request/ack transaction, with lane steering,
// load extension, alignment checking and an ack timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESPOND} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_lane;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (size)
      2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   return a[1] ? {{16{sgn & d[31]}}, d[31:16]} : {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      lat_write           <= 1'b0;
      lat_size            <= 2'b00;
      lat_signed          <= 1'b0;
      lat_lane            <= 2'b00;
      bus.req_ready       <= 1'b1;
      bus.stall           <= 1'b0;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_error      <= 1'b0;
      bus.mem_req         <= 1'b0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_be          <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write     <= bus.req_write;
            lat_size      <= bus.req_size;
            lat_signed    <= bus.req_signed;
            lat_lane      <= bus.req_addr[1:0];
            bus.req_ready <= 1'b0;
            bus.stall     <= 1'b1;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state               <= RESPOND;
              bus.resp_valid      <= 1'b1;
              bus.resp_misaligned <= 1'b1;
              bus.resp_error      <= 1'b0;
              bus.resp_rdata      <= '0;
            end else begin
              state         <= WAIT_ACK;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_write;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              // Byte enables qualify store lanes only; loads always fetch the whole word.
              bus.mem_be    <= bus.req_write ? byte_en(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
              bus.mem_wdata <= lane_rep(bus.req_size, bus.req_wdata);
            end
          end
        end
        WAIT_ACK: begin
          // Ack takes priority over the timeout when both land in the same cycle.
          if (bus.mem_ack || cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state          <= RESPOND;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= !bus.mem_ack;
            bus.resp_rdata <= (bus.mem_ack && !lat_write)
                              ? load_ext(lat_size, lat_signed, lat_lane, bus.mem_rdata) : '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state               <= IDLE;
          cnt                 <= '0;
          bus.req_ready       <= 1'b1;
          bus.stall           <= 1'b0;
          bus.resp_valid      <= 1'b0;
          bus.resp_rdata      <= '0;
          bus.resp_misaligned <= 1'b0;
          bus.resp_error      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a short ack timeout.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
    logic        err;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.resp_valid) begin
      if (q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rd);
        chk("resp_mis", {31'd0, bus.resp_misaligned}, {31'd0, e.mis});
        chk("resp_err", {31'd0, bus.resp_error}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, bus.req_ready}, 32'd1);
  endtask

  // ack_at: mem_req cycle (1-based) in which ack is returned; 0 = never.
  task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                    input int ack_at, input logic [31:0] exp_rd, input logic exp_mis,
                    input logic exp_err, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int req_cycles = 0;
    int n = 0;
    exp_t e;
    wait_ready();
    @(negedge clk);
    bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = ad; bus.req_wdata = wd; bus.req_valid = 1'b1;
    e.rd = exp_rd; e.mis = exp_mis; e.err = exp_err;
    q.push_back(e);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    chk("stall_busy", {31'd0, bus.stall}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!bus.mem_req) begin
        chk("resp_timing", {31'd0, bus.resp_valid}, 32'd1);
        break;
      end
      req_cycles++;
      chk("mem_addr", bus.mem_addr, {ad[31:2], 2'b00});
      chk("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
      chk("mem_be", {28'd0, bus.mem_be}, {28'd0, exp_be});
      chk("mem_wdata", bus.mem_wdata, exp_wd);
      if (k == ack_at) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        @(posedge clk); #1 bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        chk("resp_timing", {31'd0, bus.resp_valid}, 32'd1);
        chk("req_drop", {31'd0, bus.mem_req}, 32'd0);
        break;
      end
    end
    chk("req_cycles", req_cycles, exp_mis ? 0 : (ack_at == 0 ? TMO : ack_at));
    #1;
    while (q.size() != 0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("resp_seen", q.size(), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #12;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_memreq", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    //  wr  sz     sg  addr          wdata         rdata         ack  exp_rd        mis  err  be       wd
    op(0, 2'b00, 1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'hFFFF_FF80, 0, 0, 4'b0000, 32'h0);
    op(0, 2'b00, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 1, 32'h0000_0080, 0, 0, 4'b0000, 32'h0);
    op(1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h0,        3, 32'h0,         0, 0, 4'b1100, 32'hBEEF_BEEF);
    op(0, 2'b10, 0, 32'h0000_3001, 32'h0,        32'h0,         1, 32'h0,         1, 0, 4'b0000, 32'h0);
    op(0, 2'b01, 0, 32'h0000_3001, 32'h0,        32'h0,         1, 32'h0,         1, 0, 4'b0000, 32'h0);
    op(0, 2'b11, 0, 32'h0000_3000, 32'h0,        32'h0,         1, 32'h0,         1, 0, 4'b0000, 32'h0);
    op(0, 2'b10, 0, 32'h0000_4000, 32'h0,        32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0);
    op(0, 2'b10, 0, 32'h0000_4004, 32'h0,        32'h1234_5678, 2, 32'h1234_5678, 0, 0, 4'b0000, 32'h0);
    op(0, 2'b01, 1, 32'h0000_5002, 32'h0,        32'h8001_7FFF, TMO, 32'hFFFF_8001, 0, 0, 4'b0000, 32'h0);
    op(1, 2'b00, 0, 32'h0000_6001, 32'h0000_00A5, 32'h0,        1, 32'h0,         0, 0, 4'b0010, 32'hA5A5_A5A5);
    op(0, 2'b01, 0, 32'h0000_5000, 32'h0,        32'h1234_F00D, 2, 32'h0000_F00D, 0, 0, 4'b0000, 32'h0);
    op(0, 2'b00, 1, 32'h0000_5001, 32'h0,        32'h0000_7F00, 1, 32'h0000_007F, 0, 0, 4'b0000, 32'h0);
    op(1, 2'b10, 0, 32'h0000_6008, 32'hCAFE_F00D, 32'h0,        2, 32'h0,         0, 0, 4'b1111, 32'hCAFE_F00D);

    // Stray acks while idle must not produce a response.
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk); chk("stray_ack", {31'd0, bus.resp_valid}, 32'd0);
    end

    // Reset during WAIT_ACK abandons the transaction immediately.
    wait_ready();
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_addr = 32'h0000_7000;
    bus.req_wdata = 32'h1111_2222; bus.req_valid = 1'b1;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk); chk("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_memreq", {31'd0, bus.mem_req}, 32'd0);
    chk("async_stall", {31'd0, bus.stall}, 32'd0);
    chk("async_resp", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.mem_ack = 1'b1;
    @(posedge clk); #1 bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("post_rst_noresp", {31'd0, bus.resp_valid}, 32'd0);
    end
    op(0, 2'b10, 0, 32'h0000_7000, 32'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0, 0, 4'b0000, 32'h0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
